regfile_wb_ctrl: RTL and testbench

Write-side initiator for the 32x32 integer register file. It merges single-cycle ALU results and multi-cycle load results, buffering loads in a small FIFO. It drives one registered write per cycle into the register file's rd/we/wdata port and keeps a 32-bit busy scoreboard of destinations with an outstanding write. It sits between execute/memory stages and the register file.

---
 rtl/regfile_wb_ctrl.sv | 188 ++++++++++++++++++
 tb/tb_regfile_wb_ctrl.sv | 341 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_wb_ctrl.sv
// Register-file write-back initiator: merges ALU results with FIFO-buffered load
// results into one registered write per cycle and keeps a pending-write scoreboard.
module regfile_wb_ctrl #(
    parameter int DEPTH      = 4,
    parameter int STARVE_MAX = 3
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        alu_valid,
    input  logic [4:0]  alu_rd,
    input  logic [31:0] alu_data,
    output logic        alu_stall,
    input  logic        mem_valid,
    output logic        mem_ready,
    input  logic [4:0]  mem_rd,
    input  logic [31:0] mem_data,
    input  logic        issue_valid,
    input  logic [4:0]  issue_rd,
    output logic [31:0] busy,
    output logic        rf_we,
    output logic [4:0]  rf_rd,
    output logic [31:0] rf_wdata
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam int SW = $clog2(STARVE_MAX + 1);
    localparam logic [CW-1:0] FULL_C   = CW'(DEPTH);
    localparam logic [SW-1:0] STARVE_C = SW'(STARVE_MAX);

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_FORCE = 1'b1
    } state_e;

    state_e         state_q, state_d;
    logic [SW-1:0]  starve_q, starve_d;
    logic [PW-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]  count_q, count_d;
    logic [31:0]    busy_q, busy_d;
    logic           rf_we_q, rf_we_d;
    logic [4:0]     rf_rd_q, rf_rd_d;
    logic [31:0]    rf_wdata_q, rf_wdata_d;

    logic [4:0]     fifo_rd_q   [DEPTH];
    logic [31:0]    fifo_data_q [DEPTH];

    logic           push_s;
    logic           pop_s;
    logic           alu_sel_s;
    logic           fifo_empty_s;
    logic           sel_valid_s;
    logic [4:0]     sel_rd_s;
    logic [31:0]    sel_data_s;
    logic [SW-1:0]  starve_inc_s;

    assign mem_ready    = (count_q != FULL_C);
    assign alu_stall    = (state_q == ST_FORCE);
    assign fifo_empty_s = (count_q == {CW{1'b0}});
    assign busy         = busy_q;
    assign rf_we        = rf_we_q;
    assign rf_rd        = rf_rd_q;
    assign rf_wdata     = rf_wdata_q;

    // Source arbitration: a forced cycle drains the FIFO head, otherwise ALU has priority.
    always_comb begin
        pop_s       = 1'b0;
        alu_sel_s   = 1'b0;
        sel_valid_s = 1'b0;
        sel_rd_s    = 5'd0;
        sel_data_s  = 32'd0;
        push_s      = mem_valid && mem_ready;
        if (state_q == ST_FORCE) begin
            pop_s = !fifo_empty_s;
        end else if (alu_valid) begin
            alu_sel_s = 1'b1;
        end else begin
            pop_s = !fifo_empty_s;
        end
        if (alu_sel_s) begin
            sel_valid_s = 1'b1;
            sel_rd_s    = alu_rd;
            sel_data_s  = alu_data;
        end else if (pop_s) begin
            sel_valid_s = 1'b1;
            sel_rd_s    = fifo_rd_q[rd_ptr_q];
            sel_data_s  = fifo_data_q[rd_ptr_q];
        end else begin
            sel_valid_s = 1'b0;
        end
    end

    // FIFO pointer and occupancy update; pointers wrap naturally at the power-of-two depth.
    always_comb begin
        wr_ptr_d = push_s ? (wr_ptr_q + 1'b1) : wr_ptr_q;
        rd_ptr_d = pop_s  ? (rd_ptr_q + 1'b1) : rd_ptr_q;
        case ({push_s, pop_s})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    // Starvation FSM: count ALU wins over a waiting load, then force one FIFO pop.
    always_comb begin
        state_d      = state_q;
        starve_d     = starve_q;
        starve_inc_s = starve_q + 1'b1;
        case (state_q)
            ST_IDLE: begin
                if (pop_s || fifo_empty_s) begin
                    starve_d = {SW{1'b0}};
                end else if (alu_sel_s) begin
                    if (starve_inc_s == STARVE_C) begin
                        state_d  = ST_FORCE;
                        starve_d = STARVE_C;
                    end else begin
                        starve_d = starve_inc_s;
                    end
                end else begin
                    starve_d = starve_q;
                end
            end
            ST_FORCE: begin
                state_d  = ST_IDLE;
                starve_d = {SW{1'b0}};
            end
            default: begin
                state_d  = ST_IDLE;
                starve_d = {SW{1'b0}};
            end
        endcase
    end

    // Write port and scoreboard; a new reservation outranks a commit to the same register.
    always_comb begin
        rf_we_d    = sel_valid_s && (sel_rd_s != 5'd0);
        rf_rd_d    = sel_valid_s ? sel_rd_s : rf_rd_q;
        rf_wdata_d = sel_valid_s ? sel_data_s : rf_wdata_q;
        busy_d     = busy_q;
        if (rf_we_q) begin
            busy_d[rf_rd_q] = 1'b0;
        end else begin
            busy_d = busy_d;
        end
        if (issue_valid && (issue_rd != 5'd0)) begin
            busy_d[issue_rd] = 1'b1;
        end else begin
            busy_d = busy_d;
        end
        busy_d[0] = 1'b0;
    end

    // Control and output registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            starve_q   <= {SW{1'b0}};
            wr_ptr_q   <= {PW{1'b0}};
            rd_ptr_q   <= {PW{1'b0}};
            count_q    <= {CW{1'b0}};
            busy_q     <= 32'd0;
            rf_we_q    <= 1'b0;
            rf_rd_q    <= 5'd0;
            rf_wdata_q <= 32'd0;
        end else begin
            state_q    <= state_d;
            starve_q   <= starve_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            busy_q     <= busy_d;
            rf_we_q    <= rf_we_d;
            rf_rd_q    <= rf_rd_d;
            rf_wdata_q <= rf_wdata_d;
        end
    end

    // Load-result storage; validity is tracked by the pointers, so no reset is needed.
    always_ff @(posedge clk) begin
        if (push_s) begin
            fifo_rd_q[wr_ptr_q]   <= mem_rd;
            fifo_data_q[wr_ptr_q] <= mem_data;
        end
    end

endmodule

// File: tb/tb_regfile_wb_ctrl.sv
// Self-checking bench for regfile_wb_ctrl: directed scenarios plus randomized
// traffic compared against a queue-based behavioural model.
module tb_regfile_wb_ctrl;

    localparam int DEPTH      = 4;
    localparam int STARVE_MAX = 3;

    typedef struct packed {
        logic [4:0]  rd;
        logic [31:0] data;
    } ld_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        alu_valid = 1'b0;
    logic [4:0]  alu_rd = 5'd0;
    logic [31:0] alu_data = 32'd0;
    logic        alu_stall;
    logic        mem_valid = 1'b0;
    logic        mem_ready;
    logic [4:0]  mem_rd = 5'd0;
    logic [31:0] mem_data = 32'd0;
    logic        issue_valid = 1'b0;
    logic [4:0]  issue_rd = 5'd0;
    logic [31:0] busy;
    logic        rf_we;
    logic [4:0]  rf_rd;
    logic [31:0] rf_wdata;

    int n_checks = 0;
    int n_pass   = 0;

    // Behavioural model state
    ld_t         mq[$];
    int          m_starve;
    bit          m_stall;
    logic        m_we;
    logic [4:0]  m_rd;
    logic [31:0] m_data;
    logic [31:0] m_busy;

    regfile_wb_ctrl #(.DEPTH(DEPTH), .STARVE_MAX(STARVE_MAX)) dut (
        .clk(clk), .reset(reset),
        .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_data(alu_data), .alu_stall(alu_stall),
        .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_rd(mem_rd), .mem_data(mem_data),
        .issue_valid(issue_valid), .issue_rd(issue_rd), .busy(busy),
        .rf_we(rf_we), .rf_rd(rf_rd), .rf_wdata(rf_wdata)
    );

    always #5 clk = ~clk;

    task automatic model_clear();
        mq.delete();
        m_starve = 0;
        m_stall  = 1'b0;
        m_we     = 1'b0;
        m_rd     = 5'd0;
        m_data   = 32'd0;
        m_busy   = 32'd0;
    endtask

    // One clock of the model, computed from the current inputs and model state.
    task automatic model_step();
        bit          ne   = (mq.size() != 0);
        bit          push = mem_valid && (mq.size() < DEPTH);
        bit          pop  = 1'b0;
        bit          asel = 1'b0;
        ld_t         head;
        logic        nwe  = 1'b0;
        logic [4:0]  nrd  = m_rd;
        logic [31:0] nd   = m_data;
        logic [31:0] nb   = m_busy;
        if (m_stall) pop = ne;
        else if (alu_valid) asel = 1'b1;
        else pop = ne;
        if (asel) begin
            nwe = (alu_rd != 5'd0); nrd = alu_rd; nd = alu_data;
        end else if (pop) begin
            head = mq.pop_front();
            nwe = (head.rd != 5'd0); nrd = head.rd; nd = head.data;
        end
        if (m_we) nb[m_rd] = 1'b0;
        if (issue_valid && issue_rd != 5'd0) nb[issue_rd] = 1'b1;
        nb[0] = 1'b0;
        if (m_stall) begin
            m_stall = 1'b0; m_starve = 0;
        end else if (ne && asel) begin
            m_starve++;
            if (m_starve == STARVE_MAX) begin
                m_stall = 1'b1; m_starve = 0;
            end
        end else begin
            m_starve = 0;
        end
        if (push) mq.push_back({mem_rd, mem_data});
        m_we = nwe; m_rd = nrd; m_data = nd; m_busy = nb;
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        alu_valid = 1'b0; alu_rd = 5'd0; alu_data = 32'd0;
        mem_valid = 1'b0; mem_rd = 5'd0; mem_data = 32'd0;
        issue_valid = 1'b0; issue_rd = 5'd0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        idle_inputs();
        model_clear();
        @(posedge clk);
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        for (int i = 0; i < 10; i++) begin
            tick();
            n_checks++;
            if ({rf_we, alu_stall, mem_ready} !== 3'b001)
                $display("FAIL reset_ctl: got we/stall/ready=%b required 001", {rf_we, alu_stall, mem_ready});
            else n_pass++;
            n_checks++;
            if (busy !== 32'd0 || rf_rd !== 5'd0 || rf_wdata !== 32'd0)
                $display("FAIL reset_regs: got busy=%h rd=%0d wdata=%h required 0/0/0", busy, rf_rd, rf_wdata);
            else n_pass++;
        end
    endtask

    task automatic test_alu_single();
        do_reset();
        alu_valid = 1'b1; alu_rd = 5'd5; alu_data = 32'hDEADBEEF;
        tick();
        alu_valid = 1'b0;
        n_checks++;
        if ({rf_we, rf_rd, rf_wdata} !== {1'b1, 5'd5, 32'hDEADBEEF})
            $display("FAIL alu_single: got we=%b rd=%0d data=%h required 1/5/deadbeef", rf_we, rf_rd, rf_wdata);
        else n_pass++;
        tick();
        n_checks++;
        if (rf_we !== 1'b0) $display("FAIL alu_single_off: got we=%b required 0", rf_we);
        else n_pass++;
    endtask

    task automatic test_load_order();
        do_reset();
        for (int k = 1; k <= 6; k++) begin
            mem_valid = (k <= 4);
            mem_rd    = 5'(k);
            mem_data  = 32'h10 + 32'(k - 1);
            tick();
            n_checks++;
            if (k >= 2 && k <= 5) begin
                if ({rf_we, rf_rd, rf_wdata} !== {1'b1, 5'(k - 1), 32'h10 + 32'(k - 2)})
                    $display("FAIL load_order[%0d]: got we=%b rd=%0d data=%h required 1/%0d/%h",
                             k, rf_we, rf_rd, rf_wdata, k - 1, 32'h10 + 32'(k - 2));
                else n_pass++;
            end else begin
                if (rf_we !== 1'b0) $display("FAIL load_order_idle[%0d]: got we=%b required 0", k, rf_we);
                else n_pass++;
            end
        end
        mem_valid = 1'b0;
    endtask

    task automatic test_fifo_full();
        do_reset();
        alu_valid = 1'b1; alu_rd = 5'd3; alu_data = 32'hA1;
        for (int k = 1; k <= 4; k++) begin
            mem_valid = 1'b1; mem_rd = 5'(k); mem_data = 32'h10 + 32'(k - 1);
            tick();
            n_checks++;
            if ({rf_we, rf_rd} !== {1'b1, 5'd3})
                $display("FAIL full_alu[%0d]: got we=%b rd=%0d required 1/3", k, rf_we, rf_rd);
            else n_pass++;
        end
        n_checks++;
        if ({mem_ready, alu_stall} !== 2'b01)
            $display("FAIL full_ready: got ready/stall=%b required 01", {mem_ready, alu_stall});
        else n_pass++;
        mem_valid = 1'b1; mem_rd = 5'd20; mem_data = 32'h55;
        tick();
        alu_valid = 1'b0; mem_valid = 1'b0;
        for (int k = 1; k <= 5; k++) begin
            n_checks++;
            if (k <= 4) begin
                if ({rf_we, rf_rd, rf_wdata} !== {1'b1, 5'(k), 32'h10 + 32'(k - 1)})
                    $display("FAIL full_drain[%0d]: got we=%b rd=%0d data=%h required 1/%0d/%h",
                             k, rf_we, rf_rd, rf_wdata, k, 32'h10 + 32'(k - 1));
                else n_pass++;
            end else begin
                if (rf_we !== 1'b0) $display("FAIL full_reject: got we=%b rd=%0d required no write", rf_we, rf_rd);
                else n_pass++;
            end
            tick();
        end
    endtask

    task automatic test_starve();
        logic [31:0] exp_d;
        do_reset();
        mem_valid = 1'b1; mem_rd = 5'd12; mem_data = 32'hAA;
        tick();
        mem_valid = 1'b0;
        for (int k = 2; k <= 6; k++) begin
            alu_valid = 1'b1; alu_rd = 5'd7;
            alu_data  = 32'h70 + 32'((k - 2 < 3) ? k - 2 : 3);
            tick();
            exp_d = (k == 5) ? 32'hAA : ((k == 6) ? 32'h73 : 32'h70 + 32'(k - 2));
            n_checks++;
            if ({rf_we, rf_rd, rf_wdata} !== {1'b1, (k == 5) ? 5'd12 : 5'd7, exp_d})
                $display("FAIL starve_wr[%0d]: got we=%b rd=%0d data=%h required data %h", k, rf_we, rf_rd, rf_wdata, exp_d);
            else n_pass++;
            n_checks++;
            if (alu_stall !== (k == 4))
                $display("FAIL starve_stall[%0d]: got %b required %b", k, alu_stall, (k == 4));
            else n_pass++;
        end
        alu_valid = 1'b0;
    endtask

    task automatic test_scoreboard();
        do_reset();
        issue_valid = 1'b1; issue_rd = 5'd9; alu_valid = 1'b1; alu_rd = 5'd9; alu_data = 32'h99;
        tick();
        alu_valid = 1'b0;
        n_checks++;
        if (busy !== 32'h200 || rf_we !== 1'b1)
            $display("FAIL sb_set: got busy=%h we=%b required 00000200/1", busy, rf_we);
        else n_pass++;
        tick();
        n_checks++;
        if (busy !== 32'h200) $display("FAIL sb_setwins: got busy=%h required 00000200", busy);
        else n_pass++;
        issue_rd = 5'd0;
        tick();
        issue_valid = 1'b0;
        n_checks++;
        if (busy !== 32'h200) $display("FAIL sb_x0: got busy=%h required 00000200", busy);
        else n_pass++;
        mem_valid = 1'b1; mem_rd = 5'd0; mem_data = 32'h1234;
        tick();
        mem_valid = 1'b0;
        tick();
        n_checks++;
        if ({rf_we, mem_ready} !== 2'b01)
            $display("FAIL sb_load_x0: got we/ready=%b required 01", {rf_we, mem_ready});
        else n_pass++;
        alu_valid = 1'b1; alu_rd = 5'd9; alu_data = 32'h5;
        tick();
        alu_valid = 1'b0;
        tick();
        n_checks++;
        if (busy !== 32'd0) $display("FAIL sb_clear: got busy=%h required 00000000", busy);
        else n_pass++;
    endtask

    task automatic test_async_reset();
        do_reset();
        issue_valid = 1'b1; issue_rd = 5'd4;
        tick();
        alu_valid = 1'b1; alu_rd = 5'd20; alu_data = 32'h7;
        for (int k = 0; k < 3; k++) begin
            issue_rd = 5'(5 + k);
            mem_valid = 1'b1; mem_rd = 5'(1 + k); mem_data = 32'hC0 + 32'(k);
            tick();
        end
        idle_inputs();
        n_checks++;
        if (busy !== 32'hF0 || mem_ready !== 1'b1)
            $display("FAIL arst_pre: got busy=%h ready=%b required 000000f0/1", busy, mem_ready);
        else n_pass++;
        #2;
        reset = 1'b1;
        model_clear();
        #1;
        n_checks++;
        if (busy !== 32'd0 || rf_we !== 1'b0 || mem_ready !== 1'b1 || alu_stall !== 1'b0)
            $display("FAIL arst_now: got busy=%h we=%b ready=%b stall=%b required 0/0/1/0", busy, rf_we, mem_ready, alu_stall);
        else n_pass++;
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;
        for (int k = 0; k < 6; k++) begin
            tick();
            n_checks++;
            if (rf_we !== 1'b0) $display("FAIL arst_stale[%0d]: got we=%b rd=%0d required 0", k, rf_we, rf_rd);
            else n_pass++;
        end
    endtask

    task automatic test_random();
        do_reset();
        for (int i = 0; i < 1500; i++) begin
            if (!(m_stall && alu_valid)) begin
                alu_valid = ($urandom_range(0, 99) < 45);
                alu_rd    = 5'($urandom_range(0, 31));
                alu_data  = $urandom;
            end
            mem_valid   = ($urandom_range(0, 99) < 50);
            mem_rd      = 5'($urandom_range(0, 31));
            mem_data    = $urandom;
            issue_valid = ($urandom_range(0, 99) < 30);
            issue_rd    = 5'($urandom_range(0, 31));
            tick();
            n_checks++;
            if ({rf_we, alu_stall, mem_ready, busy} !== {m_we, m_stall, (mq.size() < DEPTH), m_busy})
                $display("FAIL rand_ctl[%0d]: got we=%b stall=%b ready=%b busy=%h required %b/%b/%b/%h",
                         i, rf_we, alu_stall, mem_ready, busy, m_we, m_stall, (mq.size() < DEPTH), m_busy);
            else n_pass++;
            if (m_we) begin
                n_checks++;
                if ({rf_rd, rf_wdata} !== {m_rd, m_data})
                    $display("FAIL rand_wr[%0d]: got rd=%0d data=%h required %0d/%h", i, rf_rd, rf_wdata, m_rd, m_data);
                else n_pass++;
            end
        end
        idle_inputs();
    endtask

    initial begin
        test_reset();
        test_alu_single();
        test_load_order();
        test_fifo_full();
        test_starve();
        test_scoreboard();
        test_async_reset();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
